// File: rtl/mux_rr_sched.sv
// rtl/mux_rr_sched.sv - round-robin scheduler for a shared 8:1 bit-select mux with valid/ready output
// Optional MUX_RR_PRIO_EN adds a priority channel override (prio_vld/prio_ch) for new grants.
module mux_rr_sched #(
    parameter int BURST = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] req,
    input  logic       ready,
`ifdef MUX_RR_PRIO_EN
    input  logic       prio_vld,
    input  logic [2:0] prio_ch,
`endif
    output logic [2:0] sel,
    output logic [7:0] gnt,
    output logic       valid
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [3:0] BURST_LAST = 4'(BURST - 1);

    state_t     state, state_nxt;
    logic [2:0] ptr, ptr_nxt;
    logic [2:0] sel_nxt;
    logic [3:0] beat, beat_nxt;
    logic       prio_act, prio_act_nxt;

    logic       rr_found;
    logic [2:0] rr_sel;
    logic [2:0] idx;
    logic       prio_hit;
    logic [2:0] prio_sel;

`ifdef MUX_RR_PRIO_EN
    assign prio_hit = prio_vld & req[prio_ch];
    assign prio_sel = prio_ch;
`else
    assign prio_hit = 1'b0;
    assign prio_sel = 3'd0;
`endif

    // Walk from the farthest offset back to ptr so the nearest set request wins.
    always_comb begin
        rr_found = 1'b0;
        rr_sel   = ptr;
        idx      = ptr;
        for (int i = 7; i >= 0; i--) begin
            idx = ptr + 3'(i);
            if (req[idx]) begin
                rr_found = 1'b1;
                rr_sel   = idx;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        sel_nxt      = sel;
        beat_nxt     = beat;
        prio_act_nxt = prio_act;
        case (state)
            IDLE: begin
                if (en && rr_found) begin
                    state_nxt = GRANT;
                    beat_nxt  = 4'd0;
                    if (prio_hit) begin
                        sel_nxt      = prio_sel;
                        prio_act_nxt = 1'b1;
                    end else begin
                        sel_nxt      = rr_sel;
                        prio_act_nxt = 1'b0;
                    end
                end
            end
            GRANT: begin
                if (ready) begin
                    if (beat == BURST_LAST || !req[sel]) begin
                        state_nxt = IDLE;
                        // A priority grant leaves the round-robin position untouched.
                        if (!prio_act) begin
                            ptr_nxt = sel + 3'd1;
                        end
                    end else begin
                        beat_nxt = beat + 4'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= 3'd0;
            sel      <= 3'd0;
            beat     <= 4'd0;
            prio_act <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            sel      <= sel_nxt;
            beat     <= beat_nxt;
            prio_act <= prio_act_nxt;
        end
    end

    assign valid = (state == GRANT);
    assign gnt   = valid ? (8'd1 << sel) : 8'd0;

endmodule

// File: tb/tb_mux_rr_sched.sv
// tb/tb_mux_rr_sched.sv - self-checking bench for mux_rr_sched with BURST=1 and BURST=4 instances
module tb_mux_rr_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] req;
    logic       ready;
    logic [2:0] sel_o   [2];
    logic [7:0] gnt_o   [2];
    logic       valid_o [2];

    localparam int BL0 = 1;
    localparam int BL1 = 4;
    int bl [2] = '{BL0, BL1};

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

`ifdef MUX_RR_PRIO_EN
    logic       prio_vld = 1'b0;
    logic [2:0] prio_ch  = 3'd0;
`endif

    mux_rr_sched #(.BURST(BL0)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req), .ready(ready),
`ifdef MUX_RR_PRIO_EN
        .prio_vld(prio_vld), .prio_ch(prio_ch),
`endif
        .sel(sel_o[0]), .gnt(gnt_o[0]), .valid(valid_o[0])
    );

    mux_rr_sched #(.BURST(BL1)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req), .ready(ready),
`ifdef MUX_RR_PRIO_EN
        .prio_vld(prio_vld), .prio_ch(prio_ch),
`endif
        .sel(sel_o[1]), .gnt(gnt_o[1]), .valid(valid_o[1])
    );

    // Reference: a grant is a (channel, accepted-count) pair; ptr is where the next search starts.
    bit m_busy [2];
    int m_cur  [2];
    int m_cnt  [2];
    int m_ptr  [2];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_busy[k] = 0;
                m_ptr[k]  = 0;
                m_cnt[k]  = 0;
            end else if (m_busy[k]) begin
                if (ready) begin
                    m_cnt[k]++;
                    if (m_cnt[k] == bl[k] || !req[m_cur[k]]) begin
                        m_busy[k] = 0;
                        m_ptr[k]  = (m_cur[k] + 1) % 8;
                    end
                end
            end else if (en && req != 8'h00) begin
                for (int o = 0; o < 8; o++) begin
                    if (req[(m_ptr[k] + o) % 8]) begin
                        m_cur[k] = (m_ptr[k] + o) % 8;
                        break;
                    end
                end
                m_busy[k] = 1;
                m_cnt[k]  = 0;
            end
        end
    endtask

    task automatic model_check();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("model_valid[b%0d]", bl[k]), valid_o[k], m_busy[k]);
            chk($sformatf("model_gnt[b%0d]", bl[k]), gnt_o[k], m_busy[k] ? (1 << m_cur[k]) : 0);
            if (m_busy[k])
                chk($sformatf("model_sel[b%0d]", bl[k]), sel_o[k], m_cur[k]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        model_check();
    endtask

    typedef struct {
        logic [7:0] req;
        logic       en;
        logic       ready;
        logic       exp_valid;
        logic [2:0] exp_sel;
    } vec_t;

    vec_t tbl [21];

    logic       b_valid [15] = '{1,1,1,1,0, 1,1,1,1,0, 1,1,1,0,1};
    logic [2:0] b_sel   [15] = '{0,0,0,0,0, 1,1,1,1,0, 0,0,0,0,1};

    initial begin
        if (BL0 < 1 || BL0 > 15 || BL1 < 1 || BL1 > 15) begin
            $display("FAIL burst_range BURST outside 1..15");
            $fatal(1);
        end

        // Burst-1 sequence from reset: single request, rotation, wrap-around, backpressure, enable.
        tbl[0]  = '{8'h01, 1'b1, 1'b1, 1'b1, 3'd0};
        tbl[1]  = '{8'h01, 1'b1, 1'b1, 1'b0, 3'd0};
        tbl[2]  = '{8'h01, 1'b1, 1'b1, 1'b1, 3'd0};
        tbl[3]  = '{8'h01, 1'b1, 1'b1, 1'b0, 3'd0};
        tbl[4]  = '{8'hFF, 1'b1, 1'b1, 1'b1, 3'd1};
        tbl[5]  = '{8'hFF, 1'b1, 1'b1, 1'b0, 3'd0};
        tbl[6]  = '{8'hFF, 1'b1, 1'b1, 1'b1, 3'd2};
        tbl[7]  = '{8'hFF, 1'b1, 1'b1, 1'b0, 3'd0};
        tbl[8]  = '{8'h84, 1'b1, 1'b1, 1'b1, 3'd7};
        tbl[9]  = '{8'h84, 1'b1, 1'b1, 1'b0, 3'd0};
        tbl[10] = '{8'h84, 1'b1, 1'b1, 1'b1, 3'd2};
        tbl[11] = '{8'h84, 1'b1, 1'b1, 1'b0, 3'd0};
        tbl[12] = '{8'h20, 1'b1, 1'b0, 1'b1, 3'd5};
        tbl[13] = '{8'h20, 1'b1, 1'b0, 1'b1, 3'd5};
        tbl[14] = '{8'h20, 1'b1, 1'b0, 1'b1, 3'd5};
        tbl[15] = '{8'h20, 1'b1, 1'b0, 1'b1, 3'd5};
        tbl[16] = '{8'h20, 1'b1, 1'b0, 1'b1, 3'd5};
        tbl[17] = '{8'h20, 1'b1, 1'b1, 1'b0, 3'd0};
        tbl[18] = '{8'h00, 1'b1, 1'b1, 1'b0, 3'd0};
        tbl[19] = '{8'hFF, 1'b0, 1'b1, 1'b0, 3'd0};
        tbl[20] = '{8'hFF, 1'b1, 1'b1, 1'b1, 3'd6};

        rst_n = 1'b0; en = 1'b1; req = 8'hFF; ready = 1'b1;
        #2;
        for (int k = 0; k < 2; k++) begin
            chk("reset_sel", sel_o[k], 0);
            chk("reset_gnt", gnt_o[k], 0);
            chk("reset_valid", valid_o[k], 0);
        end
        tick();
        tick();
        rst_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            req = tbl[i].req; en = tbl[i].en; ready = tbl[i].ready;
            tick();
            chk($sformatf("tbl%0d_valid", i), valid_o[0], tbl[i].exp_valid);
            chk($sformatf("tbl%0d_gnt", i), gnt_o[0],
                tbl[i].exp_valid ? (1 << tbl[i].exp_sel) : 0);
            if (tbl[i].exp_valid)
                chk($sformatf("tbl%0d_sel", i), sel_o[0], tbl[i].exp_sel);
        end

        // Burst-4: two full bursts, then an early finish when req[0] drops after its 2nd accept.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; en = 1'b1; ready = 1'b1; req = 8'h03;
        for (int i = 0; i < 15; i++) begin
            if (i == 13) req = 8'h02;
            tick();
            chk($sformatf("burst%0d_valid", i), valid_o[1], b_valid[i]);
            if (b_valid[i])
                chk($sformatf("burst%0d_sel", i), sel_o[1], b_sel[i]);
        end

        for (int i = 0; i < 400; i++) begin
            req   = 8'($urandom);
            en    = ($urandom_range(0, 9) != 0);
            ready = ($urandom_range(0, 9) < 7);
            tick();
        end

        // Asynchronous reset in the middle of a held grant.
        req = 8'hFF; en = 1'b1; ready = 1'b0;
        tick();
        tick();
        chk("pre_async_valid", valid_o[0], 1);
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("async_sel", sel_o[k], 0);
            chk("async_gnt", gnt_o[k], 0);
            chk("async_valid", valid_o[k], 0);
        end
        tick();
        rst_n = 1'b1;
        ready = 1'b1;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
